led_breath_multi: RTL and testbench
===================================

# led_breath_multi

Multi-channel, parametrised breathing-LED PWM controller. It generates one triangle-wave brightness ramp and derives CH phase-shifted PWM outputs from it, with per-channel enable, mode select and a global ramp hold. All timing comes from clock-enable ticks in the single w_clk domain; no derived clocks. It sits between the board key/control logic and the LED pins and replaces single-channel, fixed-period breathing demos.

## Interface
- CH, 4: number of LED channels (1..16).
- TICK_DIV, 50: w_clk cycles per PWM tick (50 MHz gives a 1 µs tick); ≥1.
- PWM_STEPS, 1000: PWM ticks per PWM frame, and also the number of brightness levels; ≥2.
- PHASE_OFS, 0: phase offset added per channel index, in ramp steps (0..2·PWM_STEPS−1).
- LED_ACTIVE_LOW, 0: 1 inverts every o_led bit at the output register.
- w_clk  in  1  system clock.
- w_rst  in  1  synchronous, active-high reset.
- i_en  in  CH  per-channel enable; 0 forces the channel inactive.
- i_mode  in  2·CH  per-channel mode, 2 bits per channel:
  - 00: breathe
  - 01: fixed on
  - 10: fixed off
  - 11: fixed half (duty PWM_STEPS/2)
- i_hold  in  1  1 freezes ramp phase; PWM keeps running.
- o_led  out  CH  registered PWM outputs.
- o_frame  out  1  one-cycle pulse on the cycle the PWM counter wraps.

## Operation
- Tick divider: counts 0..TICK_DIV−1. tick=1 on the cycle it equals TICK_DIV−1, then it wraps to 0.
- PWM counter pwm: advances on tick over 0..PWM_STEPS−1. The wrap to 0 marks the end of a frame, and o_frame pulses on that cycle.
- Ramp phase ph, width $clog2(2·PWM_STEPS):
  - Advances by 1 at each frame end unless i_hold=1.
  - Wraps from 2·PWM_STEPS−1 to 0.
- Channel k:
  - ph_k = (ph + k·PHASE_OFS) mod 2·PWM_STEPS.
  - level_k = ph_k if ph_k < PWM_STEPS, else 2·PWM_STEPS−1−ph_k.
- Duty by mode:
  - breathe: duty_k = level_k.
  - fixed on: duty_k = PWM_STEPS.
  - fixed off: duty_k = 0.
  - fixed half: duty_k = PWM_STEPS/2 (floor).
- Channel active when i_en[k]=1 and pwm < duty_k.
- o_led[k] = active XOR LED_ACTIVE_LOW, registered.
- i_mode is sampled into a shadow register at frame end, so a mode change never truncates a frame. i_en acts immediately.
- Level 0 gives a fully dark frame. Level PWM_STEPS−1 gives all ticks but one.

## Timing
- Reset: all counters, ph, mode shadow (00) and o_frame clear to 0; o_led = {CH{LED_ACTIVE_LOW}}. This takes effect on the first w_clk edge with w_rst=1, including mid-frame.
- After reset release, the first tick occurs TICK_DIV cycles later, and the first o_frame PWM_STEPS·TICK_DIV cycles later.
- o_led lags the pwm/duty comparison by 1 cycle. o_frame is registered, aligned with the wrap edge of pwm.
- Simultaneous events:
  - i_hold rising on a frame-end cycle suppresses that ph advance.
  - Mode change on a frame-end cycle is captured on that cycle.
- Full breath period = 2·PWM_STEPS frames (defaults: 1000 µs frame, 2 s breath).
- Wrap-around: ph and ph_k sums use a modulo compare and subtract, never truncation.

## Configuration
- LED_BREATH_GAMMA_EN defined:
  - In breathe mode, duty_k = (level_k·level_k) >> $clog2(PWM_STEPS).
  - PWM_STEPS must be a power of two; elaboration error otherwise.
  - Fixed modes are unaffected.
- Undefined: linear duty_k = level_k, no multiplier inferred.

## Test plan
Bench parameters: CH=2, TICK_DIV=2, PWM_STEPS=8, PHASE_OFS=8, active-high.
1. Reset: w_rst=1 for 3 cycles mid-run -> o_led=00 and o_frame=0 next edge. First o_frame 16 cycles after release.
2. Breathe ch0 (i_en=01, mode 00): per-frame high-cycle counts of o_led[0] = 0,2,4,…,14,14,12,…,0, repeating every 16 frames.
3. Phase offset: ch1 breathe too -> in the frame where ch0 level=0, ch1 level=7 (14 high cycles); the sum of levels is always 7.
4. Mode change mid-frame: set ch0 mode 01 at cycle 5 of a frame -> current frame unchanged, o_led[0]=1 continuously from the next frame. i_en[0]=0 -> o_led[0]=0 one cycle later.
5. Hold: i_hold=1 across 3 frame ends -> level constant for 4 frames; the ramp resumes at the next value after release.
6. LED_BREATH_GAMMA_EN: level 4 -> 4 high cycles (duty 2); level 7 -> 12 high cycles (duty 6). Mode 11 -> 8 high cycles regardless.

Source files
------------

// File: rtl/led_breath_multi.sv
// rtl/led_breath_multi.sv - multi-channel breathing-LED PWM controller with phase-shifted triangle ramp
// Optional macro LED_BREATH_GAMMA_EN: squared (gamma) duty in breathe mode; PWM_STEPS must be a power of two.
module led_breath_multi #(
  parameter int CH             = 4,
  parameter int TICK_DIV       = 50,
  parameter int PWM_STEPS      = 1000,
  parameter int PHASE_OFS      = 0,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic [CH-1:0]     i_en,
  input  logic [2*CH-1:0]   i_mode,
  input  logic              i_hold,
  output logic [CH-1:0]     o_led,
  output logic              o_frame
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PWM_W = $clog2(PWM_STEPS + 1);
  localparam int PH_N  = 2 * PWM_STEPS;
  localparam int PH_W  = $clog2(PH_N);

  logic [DIV_W-1:0]  div_cnt;
  logic [PWM_W-1:0]  pwm;
  logic [PH_W-1:0]   ph;
  logic [2*CH-1:0]   mode_sh;
  logic              tick;
  logic              frame_end;
  logic [CH-1:0]     active;

  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign frame_end = tick && (pwm == PWM_W'(PWM_STEPS - 1));

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      div_cnt <= '0;
      pwm     <= '0;
      ph      <= '0;
      mode_sh <= '0;
      o_frame <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        pwm <= frame_end ? '0 : pwm + 1'b1;
      end
      o_frame <= frame_end;
      // Mode is shadowed at frame end so a change never truncates a frame.
      if (frame_end) begin
        mode_sh <= i_mode;
        if (!i_hold) begin
          ph <= (ph == PH_W'(PH_N - 1)) ? '0 : ph + 1'b1;
        end
      end
    end
  end

`ifdef LED_BREATH_GAMMA_EN
  if ((1 << $clog2(PWM_STEPS)) != PWM_STEPS) begin : g_pow2_chk
    $error("led_breath_multi: PWM_STEPS must be a power of two with gamma enabled");
  end
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam int OFS = (k * PHASE_OFS) % PH_N;

    logic [PH_W:0]    ph_sum;
    logic [PH_W-1:0]  ph_k;
    logic [PH_W-1:0]  lvl_full;
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] breathe;
    logic [PWM_W-1:0] duty;

    // Compare-and-subtract keeps the modulo exact for any PWM_STEPS.
    assign ph_sum   = {1'b0, ph} + (PH_W+1)'(OFS);
    assign ph_k     = (ph_sum >= (PH_W+1)'(PH_N)) ? PH_W'(ph_sum - (PH_W+1)'(PH_N))
                                                  : ph_sum[PH_W-1:0];
    assign lvl_full = (ph_k < PH_W'(PWM_STEPS)) ? ph_k : PH_W'(PH_N - 1) - ph_k;
    assign level    = PWM_W'(lvl_full);

`ifdef LED_BREATH_GAMMA_EN
    logic [2*PWM_W-1:0] sq;
    assign sq      = level * level;
    assign breathe = PWM_W'(sq >> $clog2(PWM_STEPS));
`else
    assign breathe = level;
`endif

    always_comb begin
      duty = '0;
      case (mode_sh[2*k +: 2])
        2'b00:   duty = breathe;
        2'b01:   duty = PWM_W'(PWM_STEPS);
        2'b10:   duty = '0;
        default: duty = PWM_W'(PWM_STEPS / 2);
      endcase
    end

    assign active[k] = i_en[k] && (pwm < duty);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      o_led <= {CH{LED_ACTIVE_LOW}};
    end else begin
      o_led <= active ^ {CH{LED_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_led_breath_multi.sv
// tb/tb_led_breath_multi.sv - scoreboard bench for led_breath_multi (per-frame high-cycle counts)
module tb_led_breath_multi;

  localparam int CH        = 2;
  localparam int TICK_DIV  = 2;
  localparam int STEPS     = 8;
  localparam int PHASE_OFS = 8;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic [1:0] i_en = 2'b00;
  logic [3:0] i_mode = 4'b0000;
  logic       i_hold = 1'b0;
  logic [1:0] o_led;
  logic       o_frame;

  always #5 w_clk = ~w_clk;

  led_breath_multi #(
    .CH(CH), .TICK_DIV(TICK_DIV), .PWM_STEPS(STEPS), .PHASE_OFS(PHASE_OFS), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .w_clk(w_clk), .w_rst(w_rst), .i_en(i_en), .i_mode(i_mode), .i_hold(i_hold),
    .o_led(o_led), .o_frame(o_frame)
  );

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  bit   sb_on = 1'b0;
  int   cnt[CH];
  int   ph_m = 0;
  logic [3:0] mode_m = 4'b0000;
  int   tab[16] = '{0, 2, 4, 6, 8, 10, 12, 14, 14, 12, 10, 8, 6, 4, 2, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference duty straight from the ramp/mode rules.
  function automatic int duty_m(input int k, input int ph, input logic [1:0] m);
    int pk, lvl;
    pk  = (ph + k * PHASE_OFS) % (2 * STEPS);
    lvl = (pk < STEPS) ? pk : 2 * STEPS - 1 - pk;
    case (m)
`ifdef LED_BREATH_GAMMA_EN
      2'b00:   return (lvl * lvl) / STEPS;
`else
      2'b00:   return lvl;
`endif
      2'b01:   return STEPS;
      2'b10:   return 0;
      default: return STEPS / 2;
    endcase
  endfunction

  // Monitor: a frame's o_led samples end with the o_frame cycle (o_led lags by one).
  always @(negedge w_clk) begin
    if (w_rst) begin
      for (int k = 0; k < CH; k++) cnt[k] = 0;
    end else begin
      for (int k = 0; k < CH; k++) cnt[k] += int'(o_led[k]);
      if (o_frame) begin
        if (sb_on) begin
          for (int k = 0; k < CH; k++) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_underflow ch%0d: got count %0d with no expected entry", k, cnt[k]);
            end else begin
              check($sformatf("frame_cnt ch%0d", k), cnt[k], exp_q.pop_front());
            end
          end
        end
        for (int k = 0; k < CH; k++) cnt[k] = 0;
      end
    end
  end

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge w_clk);
      #1;
      n++;
    end while (!o_frame && n < 64);
    if (!o_frame) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no o_frame in %0d cycles, required one within %0d", n, STEPS * TICK_DIV);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
    end
  endtask

  task automatic run_frame(input logic [1:0] en, input logic [3:0] mode, input logic hold,
                           input int off, input bit use_tab, input int e0, input int e1);
    int n;
    i_en = en;
    if (use_tab) begin
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end else begin
      for (int k = 0; k < CH; k++)
        exp_q.push_back(en[k] ? duty_m(k, ph_m, mode_m[2*k +: 2]) * TICK_DIV : 0);
    end
    repeat (off) @(posedge w_clk);
    #1;
    i_mode = mode;
    i_hold = hold;
    mode_m = mode;
    if (!hold) ph_m = (ph_m + 1) % (2 * STEPS);
    wait_frame(n);
  endtask

  task automatic do_reset();
    int n;
    sb_on = 1'b0;
    exp_q.delete();
    w_rst = 1'b1;
    @(posedge w_clk);
    #1;
    check("reset_led", int'(o_led), 0);
    check("reset_frame", int'(o_frame), 0);
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    wait_frame(n);
    check("first_frame_latency", n, STEPS * TICK_DIV);
    ph_m   = i_hold ? 0 : 1;
    mode_m = i_mode;
    @(negedge w_clk);
    #1;
    sb_on = 1'b1;
  endtask

  task automatic random_frames(input int nf);
    for (int i = 0; i < nf; i++)
      run_frame(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 15), 1'b0, 0, 0);
  endtask

  initial begin
    bit tab_ok;
    int n;
`ifdef LED_BREATH_GAMMA_EN
    tab_ok = 1'b0;
`else
    tab_ok = 1'b1;
`endif
    @(posedge w_clk);
    #1;
    do_reset();

    // Linear breathe on both channels; ch1 sits half a period away (levels sum to 7).
    for (int i = 1; i <= 17; i++)
      run_frame(2'b11, 4'b0000, 1'b0, $urandom_range(0, 15), tab_ok, tab[i % 16], 14 - tab[i % 16]);

    // Hold across three frame ends, then resume.
    for (int i = 0; i < 3; i++) run_frame(2'b11, 4'b0000, 1'b1, $urandom_range(0, 15), 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) run_frame(2'b11, 4'b0000, 1'b0, $urandom_range(0, 15), 1'b0, 0, 0);

    // Mode change at cycle 5 of a frame, then fixed half / fixed off.
    run_frame(2'b01, 4'b0001, 1'b0, 5, 1'b0, 0, 0);
    run_frame(2'b01, 4'b1011, 1'b0, 0, 1'b0, 0, 0);
    run_frame(2'b11, 4'b1011, 1'b0, 9, 1'b0, 0, 0);
    run_frame(2'b11, 4'b0000, 1'b0, 15, 1'b0, 0, 0);

    random_frames(60);

    // i_en acts within one cycle, independent of frame boundaries.
    @(negedge w_clk);
    #1;
    sb_on = 1'b0;
    exp_q.delete();
    i_en   = 2'b11;
    i_mode = 4'b0101;
    i_hold = 1'b0;
    wait_frame(n);
    wait_frame(n);
    repeat (3) @(posedge w_clk);
    #1;
    check("fixed_on_both", int'(o_led), 3);
    i_en = 2'b01;
    @(posedge w_clk);
    #1;
    check("en1_drop", int'(o_led), 1);
    i_en = 2'b00;
    @(posedge w_clk);
    #1;
    check("en0_drop", int'(o_led), 0);
    i_en = 2'b11;
    @(posedge w_clk);
    #1;
    check("en_restore", int'(o_led), 3);

    // Mid-frame reset, then scoreboard resumes from a cleared ramp.
    do_reset();
    random_frames(20);

    @(negedge w_clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
